// File: rtl/array_multiplier_u16.sv
// -----------------------------------------------------------------------------
// array_multiplier_u16
//   Unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH product.
//   An AND-gate matrix forms the partial products. A carry-save array of
//   half/full-adder cells reduces them row by row. A final ripple-carry row
//   then resolves the outstanding carries into the upper product bits.
//
// Ports
//   clk      in   1          system clock, rising edge
//   rst_n    in   1          asynchronous active-low reset, clears Product
//   A        in   WIDTH      multiplicand, unsigned
//   B        in   WIDTH      multiplier, unsigned
//   Product  out  2*WIDTH    A*B, registered, one cycle latency
// -----------------------------------------------------------------------------

// Half adder: sum and carry of two bits.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// Full adder: sum and carry of three bits.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module array_multiplier_u16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product
);

    // pp[i][j] = A[j] & B[i]; weight i+j.
    logic [WIDTH-1:0][WIDTH-1:0] pp;

    // Carry-save state after row i.
    //   row_sum[i][j]   has weight i+j
    //   row_carry[i][j] has weight i+j+1
    // Row 0 has no carries, so row_carry starts at row 1.
    logic [WIDTH-1:0][WIDTH-1:0] row_sum;
    logic [WIDTH-1:1][WIDTH-1:0] row_carry;

    // Carry chain of the final ripple row.
    logic [WIDTH-2:0]            rc;

    logic [2*WIDTH-1:0]          product_d;

    // Partial-product matrix.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i] = A & {WIDTH{B[i]}};
    end

    // Row 0 passes pp[0] straight through.
    assign row_sum[0] = pp[0];

    // Rows 1..WIDTH-1. Each cell combines three terms of weight i+j:
    //   pp[i][j]
    //   row_sum[i-1][j+1]
    //   row_carry[i-1][j]
    // Where one of these terms is known to be zero, a half adder is used instead.
    for (genvar i = 1; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            if (i == 1) begin : g_first
                if (j < WIDTH - 1) begin : g_ha
                    ha_cell u_ha (
                        .a    (pp[i][j]),
                        .b    (row_sum[i-1][j+1]),
                        .sum  (row_sum[i][j]),
                        .cout (row_carry[i][j])
                    );
                end else begin : g_pass
                    // Top column of row 1: pp is the only non-zero term.
                    assign row_sum[i][j]   = pp[i][j];
                    assign row_carry[i][j] = 1'b0;
                end
            end else begin : g_next
                if (j < WIDTH - 1) begin : g_fa
                    fa_cell u_fa (
                        .a    (pp[i][j]),
                        .b    (row_sum[i-1][j+1]),
                        .cin  (row_carry[i-1][j]),
                        .sum  (row_sum[i][j]),
                        .cout (row_carry[i][j])
                    );
                end else begin : g_ha
                    ha_cell u_ha (
                        .a    (pp[i][j]),
                        .b    (row_carry[i-1][j]),
                        .sum  (row_sum[i][j]),
                        .cout (row_carry[i][j])
                    );
                end
            end
        end
        // Column 0 of each row is final: it becomes product bit i.
        assign product_d[i] = row_sum[i][0];
    end

    assign product_d[0] = row_sum[0][0];

    // Final ripple row, producing bits WIDTH+k. It adds:
    //   row_sum[WIDTH-1][k+1]
    //   row_carry[WIDTH-1][k]
    //   the ripple carry coming in from bit k-1
    for (genvar k = 0; k < WIDTH; k++) begin : g_rca
        if (k == 0) begin : g_lsb
            ha_cell u_ha (
                .a    (row_sum[WIDTH-1][k+1]),
                .b    (row_carry[WIDTH-1][k]),
                .sum  (product_d[WIDTH+k]),
                .cout (rc[k])
            );
        end else if (k < WIDTH - 1) begin : g_mid
            fa_cell u_fa (
                .a    (row_sum[WIDTH-1][k+1]),
                .b    (row_carry[WIDTH-1][k]),
                .cin  (rc[k-1]),
                .sum  (product_d[WIDTH+k]),
                .cout (rc[k])
            );
        end else begin : g_msb
            // The full product always fits in 2*WIDTH bits, so the top
            // position needs only a sum; its carry-out is always zero.
            assign product_d[WIDTH+k] = row_carry[WIDTH-1][k] ^ rc[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its D input from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Product <= '0;
        end else begin
            Product <= product_d;
        end
    end

endmodule

// File: tb/tb_array_multiplier_u16.sv
// -----------------------------------------------------------------------------
// tb_array_multiplier_u16
//   Scoreboard bench for array_multiplier_u16 (WIDTH=16).
//
//   The driver applies one operand pair per cycle, shortly after a rising
//   edge. It pushes the arithmetic product A*B into exp_q and raises
//   stim_valid.
//
//   The monitor latches stim_valid at each rising edge, because that is the
//   edge at which the DUT captures the operands. At the following falling
//   edge it pops one expected value and compares it with Product.
//
//   The reset behaviour is checked directly, outside the scoreboard.
// -----------------------------------------------------------------------------
module tb_array_multiplier_u16;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     A = '0;
    logic [W-1:0]     B = '0;
    logic [2*W-1:0]   Product;

    logic             stim_valid = 1'b0;
    logic [2*W-1:0]   exp_q[$];

    int               total = 0;
    int               bad = 0;

    array_multiplier_u16 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Product (Product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic, widened so nothing is lost.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        A = a;
        B = b;
        stim_valid = 1'b1;
        exp_q.push_back(model(a, b));
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        stim_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a capture is recorded at the rising edge and checked at the
    // following falling edge.
    initial begin
        logic           cap;
        logic [2*W-1:0] exp;
        forever begin
            @(posedge clk);
            cap = stim_valid && rst_n;
            @(negedge clk);
            if (cap) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", Product, 'x);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_product", Product, exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held: Product must stay 0 even with all-ones operands and a
        // running clock.
        A = '1;
        B = '1;
        #1;
        check("reset_initial", Product, '0);
        repeat (3) begin
            @(negedge clk);
            check("reset_held", Product, '0);
        end
        rst_n = 1'b1;

        // Directed corners and typical values
        drive(16'h0000, 16'hFFFF);
        drive(16'h0001, 16'hBEEF);
        drive(16'hFFFF, 16'h0001);
        drive(16'hFFFF, 16'hFFFF);
        drive(16'd12345, 16'd6789);
        drive(16'd256, 16'd256);
        drive(16'h8000, 16'h0002);
        idle();
        drain("drain_directed");

        // Model sanity against values fixed independently of the model
        check("model_max", model(16'hFFFF, 16'hFFFF), 32'hFFFE0001);
        check("model_typ", model(16'd12345, 16'd6789), 32'd83810205);

        // Back-to-back random traffic: one new pair on every edge
        for (int i = 0; i < 40; i++) begin
            drive(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
        end
        // Walking single bits exercise individual carry paths
        for (int i = 0; i < W; i++) begin
            drive(W'(1) << i, 16'hFFFF);
        end
        idle();
        drain("drain_random");

        // Mid-cycle asynchronous reset clears a valid, non-zero product
        @(posedge clk);
        #2;
        A = 16'hFFFF;
        B = 16'hFFFF;
        @(posedge clk);
        #2;
        check("pre_reset_value", Product, model(16'hFFFF, 16'hFFFF));
        rst_n = 1'b0;
        #1;
        check("async_clear", Product, '0);
        @(posedge clk);
        #2;
        check("reset_hold_edge", Product, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery: first edge after release loads a valid product
        drive(16'hA5A5, 16'h5A5A);
        drive(16'h1234, 16'hFEDC);
        drive(16'hFFFF, 16'hFFFE);
        idle();
        drain("drain_recovery");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
